mem_port_arbiter: RTL

- Shares the core's single unified memory port between the fetch stage (I-side, read-only) and the load/store unit (D-side, read/write).
- One transaction is outstanding at a time. The block registers the winning request, drives the memory bus handshake, and returns read data or a bus error to the owning requester.
- Provides a timeout (bus error, which feeds the exception path) and a fetch-flush abort.
- Sits between FETCH/MEM stages and the cache/memory controller.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 18 +
 rtl/mem_port_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared width, state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  typedef struct packed {
    logic we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0] wstrb;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: issue-to-response cycle counter that flags expiry at TIMEOUT
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign expire = en & (count == W'(TIMEOUT));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), one transaction at a time
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_valid,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [1:0] state, nxt;
  logic owner, drop, err_q, expire;
  logic [SW-1:0] starve;
  mem_cmd_t cmd;
  logic idle, issue, wait_s, resp, own_i, i_ok, d_win, abort, done_ok, tout, start;
  assign idle = state == ST_IDLE;
  assign issue = state == ST_ISSUE;
  assign wait_s = state == ST_WAIT;
  assign resp = state == ST_RESP;
  assign own_i = owner == OWN_I;
  // A fetch being flushed this cycle may not win arbitration
  assign i_ok = i_req & ~i_flush;
  assign d_win = d_req & ~(i_ok & (starve == SW'(STARVE_LIMIT)));
  assign start = idle & (i_ok | d_req);
  assign abort = issue & own_i & i_flush;
  assign done_ok = ~abort & ((issue & mem_gnt & mem_rvalid) | (wait_s & mem_rvalid));
  assign tout = expire & ~done_ok & ~abort;
  assign nxt = idle ? (start ? ST_ISSUE : ST_IDLE)
             : resp ? ST_IDLE
             : abort ? ST_IDLE
             : (done_ok | tout) ? ST_RESP
             : (issue & mem_gnt) ? ST_WAIT : state;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(idle),
    .en(issue | wait_s),
    .expire(expire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      owner <= OWN_I;
      drop <= 1'b0;
      err_q <= 1'b0;
      starve <= '0;
      cmd <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= nxt;
      drop <= idle ? 1'b0 : (own_i & i_flush & (wait_s | resp)) ? 1'b1 : drop;
      if (!resp) err_q <= tout;
      if (start) begin
        owner <= d_win ? OWN_D : OWN_I;
        cmd <= d_win ? {d_we, d_addr, d_wdata, d_wstrb} : {1'b0, i_addr, {DATA_WIDTH{1'b0}}, 4'h0};
        starve <= d_win ? (i_ok ? starve + 1'b1 : starve) : '0;
      end
      if (done_ok && own_i) i_rdata <= mem_rdata;
      if (done_ok && !own_i) d_rdata <= cmd.we ? '0 : mem_rdata;
    end
  assign mem_req = issue;
  assign mem_we = cmd.we;
  assign mem_addr = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_wstrb = cmd.wstrb;
  // A flush during WAIT or RESP silences the fetch reply, including a flush raised in RESP itself
  assign i_valid = resp & own_i & ~err_q & ~drop & ~i_flush;
  assign i_err = resp & own_i & err_q & ~drop & ~i_flush;
  assign d_valid = resp & ~own_i & ~err_q;
  assign d_err = resp & ~own_i & err_q;
endmodule
